// File: rtl/apb_master_arb.sv
// Two-client round-robin APB master.
// Shares one APB slave port and returns a per-transfer response.
module apb_master_arb #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   req0_valid,
  input  logic                   req0_write,
  input  logic [ADDR_SIZE-1:0]   req0_addr,
  input  logic [DATA_SIZE-1:0]   req0_wdata,
  input  logic [DATA_SIZE/8-1:0] req0_strb,
  output logic                   req0_ready,
  input  logic                   req1_valid,
  input  logic                   req1_write,
  input  logic [ADDR_SIZE-1:0]   req1_addr,
  input  logic [DATA_SIZE-1:0]   req1_wdata,
  input  logic [DATA_SIZE/8-1:0] req1_strb,
  output logic                   req1_ready,
  output logic                   rsp0_valid,
  output logic [DATA_SIZE-1:0]   rsp0_rdata,
  output logic                   rsp0_err,
  output logic                   rsp1_valid,
  output logic [DATA_SIZE-1:0]   rsp1_rdata,
  output logic                   rsp1_err,
  output logic [ADDR_SIZE-1:0]   PADDR,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [DATA_SIZE-1:0]   PWDATA,
  output logic [DATA_SIZE/8-1:0] PSTRB,
  input  logic                   PREADY,
  input  logic [DATA_SIZE-1:0]   PRDATA,
  input  logic                   PSLVERR
);

  localparam int SW = DATA_SIZE / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CLAST =
    CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          last;
  logic          owner;
  logic          grant;
  logic          accept;
  logic          expired;
  logic          done;
  logic [CW-1:0] cnt;

  // Pick the requester; on contention favour the one not served last.
  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      (req0_valid & req1_valid):  grant = ~last;
      (req1_valid & ~req0_valid): grant = 1'b1;
      default:                    grant = 1'b0;
    endcase
  end

  // Handshake and transfer-termination decode.
  always_comb begin
    req0_ready = (state == IDLE)
               & req0_valid & ~grant;
    req1_ready = (state == IDLE)
               & req1_valid & grant;
    accept     = req0_ready | req1_ready;
    expired    = ~PREADY & (cnt == CLAST);
    done       = (state == ACCESS)
               & (PREADY | expired);
  end

  // Next-state logic and APB phase outputs.
  always_comb begin
    state_nx = state;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = SETUP;
      end
      SETUP: begin
        PSEL     = 1'b1;
        state_nx = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nx;
  end

  // Capture the accepted request and advance the pointer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last   <= 1'b1;
      owner  <= 1'b0;
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (accept) begin
      last  <= grant;
      owner <= grant;
      if (grant) begin
        PADDR  <= req1_addr;
        PWRITE <= req1_write;
        PWDATA <= req1_wdata;
        PSTRB  <= req1_write ? req1_strb
                             : {SW{1'b0}};
      end else begin
        PADDR  <= req0_addr;
        PWRITE <= req0_write;
        PWDATA <= req0_wdata;
        PSTRB  <= req0_write ? req0_strb
                             : {SW{1'b0}};
      end
    end
  end

  // Count ACCESS cycles spent waiting on PREADY.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)
      cnt <= '0;
    else if (state != ACCESS)
      cnt <= '0;
    else if (!PREADY)
      cnt <= cnt + 1'b1;
  end

  // One-cycle response pulse; data and error hold afterwards.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= done & ~owner;
      rsp1_valid <= done & owner;
      if (done & ~owner) begin
        rsp0_rdata <= (PREADY & ~PWRITE)
                    ? PRDATA : '0;
        rsp0_err   <= PREADY ? PSLVERR : 1'b1;
      end
      if (done & owner) begin
        rsp1_rdata <= (PREADY & ~PWRITE)
                    ? PRDATA : '0;
        rsp1_err   <= PREADY ? PSLVERR : 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb.
// Drives both clients and a scripted APB slave.
module tb_apb_master_arb;

  logic        PCLK;
  logic        PRESETn;
  logic        req0_valid, req1_valid;
  logic        req0_write, req1_write;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic [3:0]  req0_strb, req1_strb;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        rsp0_err, rsp1_err;
  logic [4:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int checks = 0;
  int errors = 0;

  apb_master_arb #(
    .DATA_SIZE(32),
    .ADDR_SIZE(5),
    .TIMEOUT(16)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_strb(req0_strb), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_strb(req1_strb), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .rsp1_err(rsp1_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_reset();
    PRESETn = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_write = 0; req1_write = 0;
    req0_addr = 0; req1_addr = 0;
    req0_wdata = 0; req1_wdata = 0;
    req0_strb = 0; req1_strb = 0;
    PREADY = 0; PRDATA = 0; PSLVERR = 0;
    #12;
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin
      errors++;
      $display("FAIL rst_ctl got %b exp 000",
               {PSEL, PENABLE, PWRITE});
    end
    checks++;
    if ({PADDR, PWDATA, PSTRB} !== 41'h0) begin
      errors++;
      $display("FAIL rst_bus got %h exp 0",
               {PADDR, PWDATA, PSTRB});
    end
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
         req0_ready, req1_ready} !== 6'b0) begin
      errors++;
      $display("FAIL rst_hs got %b exp 0",
               {rsp0_valid, rsp1_valid, rsp0_err,
                rsp1_err, req0_ready, req1_ready});
    end
    checks++;
    if ({rsp0_rdata, rsp1_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL rst_rdata got %h exp 0",
               {rsp0_rdata, rsp1_rdata});
    end
    #5 PRESETn = 1'b1;
  endtask

  task automatic test_write_zero_wait();
    step();
    req0_valid = 1; req0_write = 1;
    req0_addr = 5'h03; req0_wdata = 32'hDEADBEEF;
    req0_strb = 4'hF; PREADY = 1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL t1_ready got %b exp 10",
               {req0_ready, req1_ready});
    end
    step();
    req0_valid = 0;
    #1;
    checks++;
    if ({PSEL, PENABLE} !== 2'b10 ||
        PADDR !== 5'h03 || PWDATA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL t1_setup got %b %h %h exp 10 03 deadbeef",
               {PSEL, PENABLE}, PADDR, PWDATA);
    end
    step();
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b111 ||
        PADDR !== 5'h03 || PSTRB !== 4'hF) begin
      errors++;
      $display("FAIL t1_access got %b %h %h exp 111 03 f",
               {PSEL, PENABLE, PWRITE}, PADDR, PSTRB);
    end
    step();
    checks++;
    if ({rsp0_valid, rsp0_err, rsp1_valid} !== 3'b100 ||
        rsp0_rdata !== 32'h0 || {PSEL, PENABLE} !== 2'b00) begin
      errors++;
      $display("FAIL t1_rsp got %b %h %b exp 100 0 00",
               {rsp0_valid, rsp0_err, rsp1_valid},
               rsp0_rdata, {PSEL, PENABLE});
    end
  endtask

  task automatic test_read_wait();
    logic seen0;
    seen0 = 0;
    step();
    req1_valid = 1; req1_write = 0;
    req1_addr = 5'h1F; req1_strb = 4'hF;
    req1_wdata = 32'h55555555; PREADY = 0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL t2_ready got %b exp 01",
               {req0_ready, req1_ready});
    end
    step();
    req1_valid = 0;
    seen0 |= rsp0_valid;
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b100 ||
        PADDR !== 5'h1F || PSTRB !== 4'h0) begin
      errors++;
      $display("FAIL t2_setup got %b %h %h exp 100 1f 0",
               {PSEL, PENABLE, PWRITE}, PADDR, PSTRB);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 2) begin
        PREADY = 1; PRDATA = 32'h12345678;
      end
      seen0 |= rsp0_valid;
      checks++;
      if ({PSEL, PENABLE} !== 2'b11 || PSTRB !== 4'h0) begin
        errors++;
        $display("FAIL t2_access%0d got %b %h exp 11 0",
                 i, {PSEL, PENABLE}, PSTRB);
      end
    end
    step();
    seen0 |= rsp0_valid;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b0 ||
        rsp1_rdata !== 32'h12345678 || PENABLE !== 1'b0) begin
      errors++;
      $display("FAIL t2_rsp got %b %b %h %b exp 1 0 12345678 0",
               rsp1_valid, rsp1_err, rsp1_rdata, PENABLE);
    end
    checks++;
    if (seen0 !== 1'b0) begin
      errors++;
      $display("FAIL t2_rsp0 got %b exp 0", seen0);
    end
  endtask

  task automatic test_round_robin();
    logic e_r0, e_r1, e_v0, e_v1;
    step();
    req0_write = 0; req0_addr = 5'h0A; req0_strb = 4'hF;
    req1_write = 1; req1_addr = 5'h15;
    req1_wdata = 32'h11112222; req1_strb = 4'h3;
    PREADY = 1; PSLVERR = 0; PRDATA = 32'hA5A5A5A5;
    for (int c = 0; c < 13; c++) begin
      req0_valid = (c <= 9);
      req1_valid = (c <= 9);
      #1;
      e_r0 = (c == 0) || (c == 6);
      e_r1 = (c == 3) || (c == 9);
      e_v0 = (c == 3) || (c == 9);
      e_v1 = (c == 6) || (c == 12);
      checks++;
      if ({req0_ready, req1_ready} !== {e_r0, e_r1} ||
          {rsp0_valid, rsp1_valid} !== {e_v0, e_v1}) begin
        errors++;
        $display("FAIL t3_c%0d rdy/rsp got %b%b exp %b%b",
                 c, {req0_ready, req1_ready},
                 {rsp0_valid, rsp1_valid},
                 {e_r0, e_r1}, {e_v0, e_v1});
      end
      if (c == 1 || c == 7) begin
        checks++;
        if (PADDR !== 5'h0A || PSTRB !== 4'h0 || PSEL !== 1) begin
          errors++;
          $display("FAIL t3_c%0d setup0 got %h %h exp 0a 0",
                   c, PADDR, PSTRB);
        end
      end
      if (c == 4 || c == 10) begin
        checks++;
        if (PADDR !== 5'h15 || PSTRB !== 4'h3 ||
            PWDATA !== 32'h11112222) begin
          errors++;
          $display("FAIL t3_c%0d setup1 got %h %h %h exp 15 3",
                   c, PADDR, PSTRB, PWDATA);
        end
      end
      if (e_v0) begin
        checks++;
        if (rsp0_rdata !== 32'hA5A5A5A5) begin
          errors++;
          $display("FAIL t3_c%0d rdata0 got %h exp a5a5a5a5",
                   c, rsp0_rdata);
        end
      end
      if (e_v1) begin
        checks++;
        if (rsp1_rdata !== 32'h0) begin
          errors++;
          $display("FAIL t3_c%0d rdata1 got %h exp 0",
                   c, rsp1_rdata);
        end
      end
      if (c < 12) step();
    end
  endtask

  task automatic test_slverr();
    step();
    req0_valid = 1; req0_write = 0; req0_addr = 5'h07;
    PREADY = 1; PSLVERR = 1; PRDATA = 32'hCAFEF00D;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL t4_ready got %b exp 1", req0_ready);
    end
    step();
    req0_valid = 0;
    step();
    step();
    checks++;
    if (rsp0_valid !== 1 || rsp0_err !== 1 ||
        rsp0_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL t4_err got %b %b %h exp 1 1 cafef00d",
               rsp0_valid, rsp0_err, rsp0_rdata);
    end
    req0_valid = 1; req0_addr = 5'h09;
    PSLVERR = 0; PRDATA = 32'h01020304;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL t4_ready2 got %b exp 1", req0_ready);
    end
    step();
    req0_valid = 0;
    step();
    step();
    checks++;
    if (rsp0_valid !== 1 || rsp0_err !== 0 ||
        rsp0_rdata !== 32'h01020304) begin
      errors++;
      $display("FAIL t4_next got %b %b %h exp 1 0 01020304",
               rsp0_valid, rsp0_err, rsp0_rdata);
    end
  endtask

  task automatic test_timeout();
    int n, acc;
    step();
    req0_valid = 1; req0_write = 0; req0_addr = 5'h04;
    PREADY = 0; PRDATA = 32'hFFFFFFFF;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL t5_ready got %b exp 1", req0_ready);
    end
    step();
    req0_valid = 0;
    n = 0; acc = 0;
    while (rsp0_valid !== 1'b1 && n < 40) begin
      if (PENABLE === 1'b1) acc++;
      n++;
      step();
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL t5_bound got %0d cycles exp <40", n);
    end
    checks++;
    if (acc != 16) begin
      errors++;
      $display("FAIL t5_access got %0d exp 16", acc);
    end
    checks++;
    if (rsp0_err !== 1 || rsp0_rdata !== 32'h0 ||
        {PSEL, PENABLE} !== 2'b00) begin
      errors++;
      $display("FAIL t5_abort got %b %h %b exp 1 0 00",
               rsp0_err, rsp0_rdata, {PSEL, PENABLE});
    end
    req1_valid = 1; req1_write = 1; req1_addr = 5'h01;
    req1_wdata = 32'h0BADF00D; req1_strb = 4'h1;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL t5_reaccept got %b exp 1", req1_ready);
    end
    PREADY = 1;
    step();
    req1_valid = 0;
    step();
    step();
    checks++;
    if (rsp1_valid !== 1 || rsp1_err !== 0) begin
      errors++;
      $display("FAIL t5_after got %b %b exp 1 0",
               rsp1_valid, rsp1_err);
    end
  endtask

  task automatic test_reset_mid();
    logic seen0, seen1;
    seen0 = 0; seen1 = 0;
    step();
    req1_valid = 1; req1_write = 1; req1_addr = 5'h11;
    PREADY = 0;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++;
      $display("FAIL t6_ready got %b exp 1", req1_ready);
    end
    step();
    req1_valid = 0;
    step();
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      errors++;
      $display("FAIL t6_access got %b exp 11",
               {PSEL, PENABLE});
    end
    PREADY = 1;
    PRESETn = 0;
    #1;
    checks++;
    if ({PSEL, PENABLE, rsp0_valid, rsp1_valid} !== 4'b0 ||
        PADDR !== 5'h0) begin
      errors++;
      $display("FAIL t6_async got %b %h exp 0000 0",
               {PSEL, PENABLE, rsp0_valid, rsp1_valid}, PADDR);
    end
    step();
    step();
    PRESETn = 1;
    req0_valid = 1; req1_valid = 1;
    req0_write = 0; req1_write = 0;
    PRDATA = 32'h00C0FFEE;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL t6_first got %b exp 10",
               {req0_ready, req1_ready});
    end
    for (int i = 0; i < 4; i++) begin
      step();
      req0_valid = 0; req1_valid = 0;
      seen0 |= rsp0_valid;
      seen1 |= rsp1_valid;
    end
    checks++;
    if ({seen0, seen1} !== 2'b10 ||
        rsp0_rdata !== 32'h00C0FFEE) begin
      errors++;
      $display("FAIL t6_after got %b %h exp 10 00c0ffee",
               {seen0, seen1}, rsp0_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_round_robin();
    test_slverr();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
